// File: rtl/compr_realign_if.sv
// compr_realign_if: fetch-side and decode-side handshakes of the realignment buffer.
// slave = buffer view; master = fetch/decode environment view.
interface compr_realign_if #(
  parameter int FETCH_W = 32
);
  logic               flush;
  logic [31:0]        redirect_pc;
  logic               fetch_valid;
  logic [FETCH_W-1:0] fetch_data;
  logic               fetch_ready;
  logic               out_valid;
  logic [31:0]        out_instr;
  logic               out_compr;
  logic [31:0]        out_pc;
  logic               out_ready;

  modport slave (
    input  flush, redirect_pc,
    input  fetch_valid, fetch_data,
    output fetch_ready,
    output out_valid, out_instr,
    output out_compr, out_pc,
    input  out_ready
  );

  modport master (
    output flush, redirect_pc,
    output fetch_valid, fetch_data,
    input  fetch_ready,
    input  out_valid, out_instr,
    input  out_compr, out_pc,
    output out_ready
  );
endinterface

// File: rtl/compr_realign_buf.sv
// compr_realign_buf: queues aligned fetch words as halfwords and emits one RV32IC
// instruction (16-bit zero-extended or 32-bit reassembled) plus its PC per handshake.
// Ports: clk, rst_n (async low), bus (compr_realign_if.slave: flush/redirect_pc,
// fetch_valid/fetch_data/fetch_ready, out_valid/out_instr/out_compr/out_pc/out_ready).
// Option macro COMPR_MISALIGN_START_EN: allow redirect to a halfword inside a fetch word.
module compr_realign_buf #(
  parameter int          FETCH_W  = 32,
  parameter int          DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  compr_realign_if.slave bus
);

  localparam int N  = FETCH_W / 16;
  localparam int AW = $clog2(DEPTH_HW);
  localparam int CW = AW + 1;
  localparam int OB = $clog2(FETCH_W / 8);
  localparam int SW = (N > 2) ? $clog2(N) : 1;

`ifdef COMPR_MISALIGN_START_EN
  localparam logic [31:0] PC_MASK = ~32'h1;
`else
  localparam logic [31:0] PC_MASK = ~32'((1 << OB) - 1);
`endif

  logic [15:0]   buf_q [DEPTH_HW];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic [SW-1:0] skip;

`ifdef COMPR_MISALIGN_START_EN
  logic [SW-1:0] skip_q, skip_d;
  assign skip = skip_q;
`else
  assign skip = '0;
`endif

  logic [15:0]   h0, h1;
  logic          is32;
  logic [CW-1:0] len;
  logic [CW-1:0] free;
  logic [CW-1:0] nadd;
  logic          vld, rdy;
  logic          push, pop;

  assign h0   = buf_q[rd_q];
  assign h1   = buf_q[rd_q + AW'(1)];
  assign is32 = &h0[1:0];
  assign len  = is32 ? CW'(2) : CW'(1);
  assign vld  = cnt_q >= len;
  assign free = CW'(DEPTH_HW) - cnt_q;
  assign rdy  = free >= CW'(N);
  assign nadd = CW'(N) - CW'(skip);

  assign push = bus.fetch_valid & rdy & ~bus.flush;
  assign pop  = vld & bus.out_ready & ~bus.flush;

  assign bus.fetch_ready = rdy;
  assign bus.out_valid   = vld;
  assign bus.out_instr   = is32 ? {h1, h0} : {16'h0, h0};
  assign bus.out_compr   = ~is32;
  assign bus.out_pc      = pc_q;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    pc_d  = pc_q;
`ifdef COMPR_MISALIGN_START_EN
    skip_d = skip_q;
`endif
    if (bus.flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      pc_d  = bus.redirect_pc & PC_MASK;
`ifdef COMPR_MISALIGN_START_EN
      skip_d = bus.redirect_pc[OB-1:1];
`endif
    end else begin
      if (push) begin
        wr_d = wr_q + AW'(nadd);
`ifdef COMPR_MISALIGN_START_EN
        skip_d = '0;
`endif
      end
      if (pop) begin
        rd_d = rd_q + AW'(len);
        pc_d = pc_q + (is32 ? 32'd4 : 32'd2);
      end
      cnt_d = cnt_q + (push ? nadd : '0)
                    - (pop ? len : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      pc_q  <= RESET_PC;
`ifdef COMPR_MISALIGN_START_EN
      skip_q <= '0;
`endif
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      pc_q  <= pc_d;
`ifdef COMPR_MISALIGN_START_EN
      skip_q <= skip_d;
`endif
    end
  end

  // Storage is not reset; halfwords below skip are dropped, the rest pack from wr_q.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < N; i++) begin
        if (i >= int'(skip)) begin
          buf_q[wr_q + AW'(i - int'(skip))] <= bus.fetch_data[16*i +: 16];
        end
      end
    end
  end

endmodule

// File: tb/tb_compr_realign_buf.sv
// tb_compr_realign_buf: table-driven vectors for compr_realign_buf (FETCH_W=32,
// DEPTH_HW=8) plus a hand-written asynchronous reset sequence.
module tb_compr_realign_buf;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk;
  logic rst_n;

  compr_realign_if #(.FETCH_W(32)) bus ();

  compr_realign_buf #(
    .FETCH_W (32),
    .DEPTH_HW(8),
    .RESET_PC(RPC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] fd;
    logic        ord;
    logic        fl;
    logic [31:0] rpc;
    logic        e_fr;
    logic        e_v;
    logic [31:0] e_ins;
    logic        e_c;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vq[$];
  int   n_vec;
  int   n_err;

  task automatic add(
    input logic fv, input logic [31:0] fd,
    input logic ord, input logic fl,
    input logic [31:0] rpc, input logic e_fr,
    input logic e_v, input logic [31:0] e_ins,
    input logic e_c, input logic [31:0] e_pc
  );
    vec_t v;
    v.fv = fv; v.fd = fd; v.ord = ord;
    v.fl = fl; v.rpc = rpc; v.e_fr = e_fr;
    v.e_v = e_v; v.e_ins = e_ins;
    v.e_c = e_c; v.e_pc = e_pc;
    vq.push_back(v);
  endtask

  task automatic chk(
    input string nm, input int row,
    input logic [31:0] act, input logic [31:0] exp
  );
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h",
               nm, row, act, exp);
    end
  endtask

  task automatic drive(
    input logic fv, input logic [31:0] fd,
    input logic ord, input logic fl,
    input logic [31:0] rpc
  );
    bus.fetch_valid = fv;
    bus.fetch_data  = fd;
    bus.out_ready   = ord;
    bus.flush       = fl;
    bus.redirect_pc = rpc;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // fv fd            ord fl rpc          fr v instr         c pc
    // two compressed from one word
    add(1, 32'h4505_4501, 1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0000_4501,1, 32'h0);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0000_4505,1, 32'h2);
    add(0, 32'h0,         1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h4);
    // straddle, after flush to 0 with junk on the fetch port
    add(1, 32'hFFFF_FFFF, 1, 1, 32'h0,     1, 0, 32'h0,        0, 32'h4);
    add(1, 32'h0093_4501, 1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0000_4501,1, 32'h0);
    add(0, 32'h0,         1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h2);
    add(1, 32'h4505_0010, 1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h2);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0010_0093,0, 32'h2);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0000_4505,1, 32'h6);
    add(0, 32'h0,         1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h8);
    // backpressure: fill to 8 halfwords, pointers wrap
    add(1, 32'h0010_0093, 0, 0, 32'h0,     1, 0, 32'h0,        0, 32'h8);
    add(1, 32'h0010_0093, 0, 0, 32'h0,     1, 1, 32'h0010_0093,0, 32'h8);
    add(1, 32'h0010_0093, 0, 0, 32'h0,     1, 1, 32'h0010_0093,0, 32'h8);
    add(1, 32'h0010_0093, 0, 0, 32'h0,     1, 1, 32'h0010_0093,0, 32'h8);
    add(1, 32'h0010_0093, 0, 0, 32'h0,     0, 1, 32'h0010_0093,0, 32'h8);
    add(1, 32'h0010_0093, 1, 0, 32'h0,     0, 1, 32'h0010_0093,0, 32'h8);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0010_0093,0, 32'hC);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0010_0093,0, 32'h10);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0010_0093,0, 32'h14);
    add(0, 32'h0,         1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h18);
    // flush mid-straddle, then simultaneous push and pop
    add(1, 32'h0093_4501, 1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h18);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0000_4501,1, 32'h18);
    add(1, 32'h4505_0010, 1, 1, 32'h100,   1, 0, 32'h0,        0, 32'h1A);
    add(1, 32'h4505_4501, 1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h100);
    add(1, 32'h4505_4501, 1, 0, 32'h0,     1, 1, 32'h0000_4501,1, 32'h100);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0000_4505,1, 32'h102);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0000_4501,1, 32'h104);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0000_4505,1, 32'h106);
    add(0, 32'h0,         1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h108);
    // redirect into the middle of a fetch word
    add(0, 32'h0,         1, 1, 32'h102,   1, 0, 32'h0,        0, 32'h108);
`ifdef COMPR_MISALIGN_START_EN
    add(1, 32'h4505_4501, 1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h102);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0000_4505,1, 32'h102);
    add(0, 32'h0,         1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h104);
`else
    add(1, 32'h4505_4501, 1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h100);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0000_4501,1, 32'h100);
    add(0, 32'h0,         1, 0, 32'h0,     1, 1, 32'h0000_4505,1, 32'h102);
    add(0, 32'h0,         1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h104);
`endif

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[r]) begin
      @(negedge clk);
      drive(vq[r].fv, vq[r].fd, vq[r].ord,
            vq[r].fl, vq[r].rpc);
      #1;
      n_vec++;
      chk("fetch_ready", r, 32'(bus.fetch_ready), 32'(vq[r].e_fr));
      chk("out_valid", r, 32'(bus.out_valid), 32'(vq[r].e_v));
      chk("out_pc", r, bus.out_pc, vq[r].e_pc);
      if (vq[r].e_v) begin
        chk("out_instr", r, bus.out_instr, vq[r].e_ins);
        chk("out_compr", r, 32'(bus.out_compr), 32'(vq[r].e_c));
      end
    end

    // queue 3 halfwords (32-bit head) then reset between edges
    @(negedge clk);
    drive(1'b1, 32'h0093_4501, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h4505_0010, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_vec++;
    chk("pre_rst_valid", 100, 32'(bus.out_valid), 32'h1);
    chk("pre_rst_instr", 100, bus.out_instr, 32'h0010_0093);
    chk("pre_rst_ready", 100, 32'(bus.fetch_ready), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    chk("async_rst_valid", 101, 32'(bus.out_valid), 32'h0);
    chk("async_rst_ready", 101, 32'(bus.fetch_ready), 32'h1);
    chk("async_rst_pc", 101, bus.out_pc, RPC);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    chk("post_rst_pc", 102, bus.out_pc, RPC);
    chk("post_rst_valid", 102, 32'(bus.out_valid), 32'h0);
    chk("post_rst_ready", 102, 32'(bus.fetch_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
